// File: rtl/model_equiv_checker.sv
// Lockstep equivalence checker for paired behavioural model outputs.
// Optional side-A alignment delay, magnitude tolerance, first-fail capture.
module model_equiv_checker #(
  parameter int WIDTH  = 25,
  parameter int N_CH   = 2,
  parameter int DELAY  = 0,
  parameter int TOL    = 0,
  parameter int WARMUP = 4,
  parameter int CNT_W  = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  en,
  input  logic                                  clr,
  input  logic                                  valid,
  input  logic [N_CH*WIDTH-1:0]                 a_in,
  input  logic [N_CH*WIDTH-1:0]                 b_in,
  output logic [N_CH-1:0]                       mismatch,
  output logic                                  fail,
  output logic [(N_CH>1?$clog2(N_CH):1)-1:0]    fail_ch,
  output logic [WIDTH-1:0]                      fail_a,
  output logic [WIDTH-1:0]                      fail_b,
  output logic [CNT_W-1:0]                      mismatch_cnt,
  output logic [1:0]                            state
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [WIDTH+1:0] TOL_V = (WIDTH+2)'(TOL);
  localparam logic [7:0] WEND = (WARMUP > 0) ? 8'(WARMUP-1) : 8'd0;
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WARM  = 2'd1,
    S_CHECK = 2'd2,
    S_FAIL  = 2'd3
  } st_t;

  st_t st;
  logic [7:0] warm;
  logic [N_CH*WIDTH-1:0] a_d;
  logic [N_CH-1:0] raw;
  logic [CH_W-1:0] sel;
  logic [WIDTH-1:0] cap_a, cap_b;
  logic counted;

  generate
    if (DELAY == 0) begin : g_nd
      assign a_d = a_in;
    end else begin : g_d
      logic [N_CH*WIDTH-1:0] dly [DELAY];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < DELAY; i++) dly[i] <= '0;
        end else begin
          dly[0] <= a_in;
          for (int i = 1; i < DELAY; i++) dly[i] <= dly[i-1];
        end
      end
      assign a_d = dly[DELAY-1];
    end
  endgenerate

  // Extra headroom bit so |most-negative diff| cannot wrap
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [WIDTH-1:0] av, bv;
    logic [WIDTH:0]   diff;
    logic [WIDTH+1:0] ext, mag;
    assign av   = a_d[k*WIDTH +: WIDTH];
    assign bv   = b_in[k*WIDTH +: WIDTH];
    assign diff = {av[WIDTH-1], av} - {bv[WIDTH-1], bv};
    assign ext  = {diff[WIDTH], diff};
    assign mag  = ext[WIDTH+1] ? (~ext + 1'b1) : ext;
    assign raw[k] = mag > TOL_V;
  end

  always_comb begin
    sel = '0;
    for (int k = N_CH-1; k >= 0; k--)
      if (raw[k]) sel = CH_W'(k);
  end

  assign cap_a   = a_d[sel*WIDTH +: WIDTH];
  assign cap_b   = b_in[sel*WIDTH +: WIDTH];
  assign counted = valid && (st == S_CHECK || st == S_FAIL);
  assign state   = st;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st           <= S_IDLE;
      warm         <= '0;
      mismatch     <= '0;
      fail         <= 1'b0;
      fail_ch      <= '0;
      fail_a       <= '0;
      fail_b       <= '0;
      mismatch_cnt <= '0;
    end else begin
      mismatch <= raw & {N_CH{valid}};
      if (clr) begin
        st           <= S_IDLE;
        warm         <= '0;
        fail         <= 1'b0;
        fail_ch      <= '0;
        fail_a       <= '0;
        fail_b       <= '0;
        mismatch_cnt <= '0;
      end else begin
        if (counted && |raw && mismatch_cnt != CMAX)
          mismatch_cnt <= mismatch_cnt + 1'b1;
        if (!en) begin
          st <= S_IDLE;
        end else begin
          unique case (st)
            S_IDLE: begin
              warm <= '0;
              st   <= (WARMUP == 0) ? S_CHECK : S_WARM;
            end
            S_WARM: begin
              if (valid) begin
                if (warm == WEND) st <= S_CHECK;
                else warm <= warm + 1'b1;
              end
            end
            S_CHECK: begin
              if (counted && |raw) begin
                st      <= S_FAIL;
                fail    <= 1'b1;
                fail_ch <= sel;
                fail_a  <= cap_a;
                fail_b  <= cap_b;
              end
            end
            S_FAIL: st <= S_FAIL;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_model_equiv_checker.sv
// Directed bench for model_equiv_checker: several parameterisations
// share one stimulus bus; each phase checks the instance it targets.
module tb_model_equiv_checker;

  localparam int W = 25;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic clr = 1'b0;
  logic valid = 1'b0;
  logic [2*W-1:0] a = '0;
  logic [2*W-1:0] b = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  logic [1:0] m0, m1, m2, m3, m4;
  logic f0, f1, f2, f3, f4;
  logic fc0, fc1, fc2, fc3, fc4;
  logic [W-1:0] fa0, fa1, fa2, fa3, fa4;
  logic [W-1:0] fb0, fb1, fb2, fb3, fb4;
  logic [15:0] c0, c1, c2, c3;
  logic [3:0] c4;
  logic [1:0] s0, s1, s2, s3, s4;

  model_equiv_checker u0 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .valid(valid),
    .a_in(a), .b_in(b), .mismatch(m0), .fail(f0), .fail_ch(fc0),
    .fail_a(fa0), .fail_b(fb0), .mismatch_cnt(c0), .state(s0));

  model_equiv_checker #(.TOL(2)) u1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .valid(valid),
    .a_in(a), .b_in(b), .mismatch(m1), .fail(f1), .fail_ch(fc1),
    .fail_a(fa1), .fail_b(fb1), .mismatch_cnt(c1), .state(s1));

  model_equiv_checker #(.DELAY(3)) u2 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .valid(valid),
    .a_in(a), .b_in(b), .mismatch(m2), .fail(f2), .fail_ch(fc2),
    .fail_a(fa2), .fail_b(fb2), .mismatch_cnt(c2), .state(s2));

  model_equiv_checker #(.DELAY(2)) u3 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .valid(valid),
    .a_in(a), .b_in(b), .mismatch(m3), .fail(f3), .fail_ch(fc3),
    .fail_a(fa3), .fail_b(fb3), .mismatch_cnt(c3), .state(s3));

  model_equiv_checker #(.CNT_W(4)) u4 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .valid(valid),
    .a_in(a), .b_in(b), .mismatch(m4), .fail(f4), .fail_ch(fc4),
    .fail_a(fa4), .fail_b(fb4), .mismatch_cnt(c4), .state(s4));

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2*W-1:0] pk(input logic [W-1:0] x0,
                                        input logic [W-1:0] x1);
    return {x1, x0};
  endfunction

  task automatic do_reset();
    #2 rst = 1'b0;
    #2 rst = 1'b1;
  endtask

  logic [W-1:0] neg_big, pos_big;

  initial begin
    neg_big = 25'h1000000;
    pos_big = 25'h0FFFFFF;

    // reset state
    #2;
    chk("rst_state", 64'(s0), 64'd0);
    chk("rst_fail", 64'(f0), 64'd0);
    chk("rst_cnt", 64'(c0), 64'd0);
    chk("rst_mm", 64'(m0), 64'd0);

    // exact match with ramps
    rst = 1'b1;
    en = 1'b1;
    valid = 1'b1;
    a = pk(25'd0, 25'd1000);
    b = a;
    tick();
    chk("warm_enter", 64'(s0), 64'd1);
    for (int i = 1; i <= 3; i++) begin
      a = pk(W'(i), W'(i + 1000)); b = a; tick();
    end
    chk("warm_hold", 64'(s0), 64'd1);
    a = pk(25'd4, 25'd1004); b = a; tick();
    chk("check_enter", 64'(s0), 64'd2);
    for (int i = 0; i < 100; i++) begin
      a = pk(W'(i * 3), W'(i * 7 + 5)); b = a; tick();
    end
    chk("ramp_fail", 64'(f0), 64'd0);
    chk("ramp_cnt", 64'(c0), 64'd0);
    chk("ramp_state", 64'(s0), 64'd2);

    // single-LSB error on ch1
    a = pk(25'd7, 25'd500); b = pk(25'd7, 25'd501); tick();
    chk("lsb_mm", 64'(m0), 64'b10);
    chk("lsb_fail", 64'(f0), 64'd1);
    chk("lsb_ch", 64'(fc0), 64'd1);
    chk("lsb_fa", 64'(fa0), 64'd500);
    chk("lsb_fb", 64'(fb0), 64'd501);
    chk("lsb_cnt", 64'(c0), 64'd1);
    chk("lsb_state", 64'(s0), 64'd3);
    chk("lsb_tol_ok", 64'(f1), 64'd0);
    a = pk(25'd8, 25'd9); b = a; tick();
    chk("lsb_clean", 64'(m0), 64'd0);
    a = pk(25'd20, 25'd9); b = pk(25'd19, 25'd9); tick();
    chk("ch0_mm", 64'(m0), 64'b01);
    chk("ch0_cnt", 64'(c0), 64'd2);
    chk("ch0_keep_ch", 64'(fc0), 64'd1);
    chk("ch0_keep_fa", 64'(fa0), 64'd500);
    chk("ch0_keep_fb", 64'(fb0), 64'd501);

    // async reset between edges while in FAIL
    #3 rst = 1'b0;
    #1;
    chk("arst_state", 64'(s0), 64'd0);
    chk("arst_fail", 64'(f0), 64'd0);
    chk("arst_cnt", 64'(c0), 64'd0);
    chk("arst_fa", 64'(fa0), 64'd0);
    chk("arst_mm", 64'(m0), 64'd0);

    // tolerance
    a = '0; b = '0;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("tol_state", 64'(s1), 64'd2);
    a = pk(25'd10, 25'd8); b = pk(25'd8, 25'd10); tick();
    chk("tol_pm2", 64'(m1), 64'b00);
    chk("tol_nofail", 64'(f1), 64'd0);
    a = pk(25'd5, 25'd3); b = pk(25'd8, 25'd3); tick();
    chk("tol_m3", 64'(m1), 64'b01);
    chk("tol_fail", 64'(f1), 64'd1);
    chk("tol_ch", 64'(fc1), 64'd0);
    chk("tol_fa", 64'(fa1), 64'd5);
    chk("tol_fb", 64'(fb1), 64'd8);
    a = pk(25'd1, neg_big); b = pk(25'd1, pos_big); tick();
    chk("tol_ext_neg", 64'(m1), 64'b10);
    a = pk(25'd1, pos_big); b = pk(25'd1, neg_big); tick();
    chk("tol_ext_pos", 64'(m1), 64'b10);
    chk("tol_cnt", 64'(c1), 64'd3);

    // alignment
    do_reset();
    for (int i = 0; i < 30; i++) begin
      a = pk(W'(i + 1), W'(i + 1));
      b = (i >= 3) ? pk(W'(i - 2), W'(i - 2)) : '0;
      tick();
    end
    chk("d3_fail", 64'(f2), 64'd0);
    chk("d3_cnt", 64'(c2), 64'd0);
    chk("d3_mm", 64'(m2), 64'd0);
    chk("d2_mm", 64'(m3), 64'b11);
    chk("d2_fail", 64'(f3), 64'd1);
    chk("d2_cnt", 64'(c3), 64'd25);
    chk("d2_state", 64'(s3), 64'd3);

    // saturation and clear
    do_reset();
    a = '0; b = pk(25'd1, 25'd0);
    for (int i = 0; i < 45; i++) tick();
    chk("sat_cnt", 64'(c4), 64'd15);
    chk("sat_fail", 64'(f4), 64'd1);
    clr = 1'b1; tick();
    clr = 1'b0;
    chk("clr_cnt", 64'(c4), 64'd0);
    chk("clr_fail", 64'(f4), 64'd0);
    chk("clr_state", 64'(s4), 64'd0);
    tick();
    chk("clr_rewarm", 64'(s4), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/model_equiv_checker.md
# model_equiv_checker

Parametrised lockstep equivalence checker for the generated analog behavioural models. It compares N_CH channel pairs of signed fixed-point model outputs (side A against side B) every valid cycle, with optional latency alignment and a magnitude tolerance. It reports per-channel mismatch, a sticky fail flag with first-failure capture, and a saturating mismatch count. It replaces the hand-written two-instance equality wrappers: model pairs instantiate into a wrapper and feed this block instead of asserting equality inline.

## Interface
- WIDTH, 25, sample width, signed two's complement (matches generated real-number width)
- N_CH, 2, number of compared channel pairs, 1..16
- DELAY, 0, pipeline stages applied to side A before compare, 0..15
- TOL, 0, maximum allowed |A−B| in LSBs; 0 = exact equality
- WARMUP, 4, valid cycles ignored after arming, 0..255
- CNT_W, 16, mismatch counter width
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- en  in  1  arm checker; deassert returns to IDLE
- clr  in  1  synchronous clear of fail, capture, counter, and state
- valid  in  1  side-B samples valid this cycle
- a_in  in  N_CH*WIDTH  side A, channel k at [k*WIDTH +: WIDTH]
- b_in  in  N_CH*WIDTH  side B, same packing
- mismatch  out  N_CH  registered per-channel compare result
- fail  out  1  sticky; set on first counted mismatch
- fail_ch  out  max(1,$clog2(N_CH))  lowest failing channel index of first failure
- fail_a, fail_b  out  WIDTH  aligned A and B samples of fail_ch at first failure
- mismatch_cnt  out  CNT_W  cycles with any counted mismatch, saturating
- state  out  2  IDLE=0, WARM=1, CHECK=2, FAIL=3

## Operation
- Side-A delay line: DELAY registers per channel, shifting every clock regardless of valid. DELAY=0 means a combinational pass-through. Delay registers reset to 0 and are not cleared by clr.
- Compare: diff = sign-extended A_d − B in WIDTH+1 bits; take the absolute value; a channel mismatches when |diff| > TOL. The most-negative diff must not overflow (use WIDTH+2 bits for abs).
- A cycle is counted only when valid=1 and state ∈ {CHECK, FAIL}. The mismatch bits are the raw compare result gated by valid, independent of state.
- FSM:
  - IDLE → WARM when en=1, with the warm counter loaded to 0. If WARMUP=0, IDLE goes directly to CHECK.
  - WARM: the counter increments on each valid cycle; → CHECK on the valid cycle where counter = WARMUP−1.
  - CHECK → FAIL on the first counted cycle with any mismatch.
  - FAIL is held until clr or en=0.
  - en=0 in WARM, CHECK, or FAIL → IDLE. fail, capture, and count are retained.
  - clr=1 → IDLE and clears fail, fail_ch, fail_a, fail_b, mismatch_cnt, and the warm counter. clr has priority over en and over a simultaneous mismatch.
- Capture: loaded only on the CHECK→FAIL transition, using the lowest-index mismatching channel. Later mismatches do not overwrite it.
- Counter: increments on every counted mismatch cycle in CHECK or FAIL (including the transition cycle); saturates at 2^CNT_W−1.

## Timing
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0; delay line 0; warm counter 0.
- B at edge t is compared with A from edge t−DELAY. mismatch, fail, capture, and count update at edge t+1 (latency 1).
- fail rises in the same cycle state first reads FAIL.
- en and clr are sampled at the clock edge. A clr and en=1 at the same edge give IDLE for one cycle, then WARM.
- Reset released mid-stream: the first DELAY cycles compare against zeros. WARMUP must be ≥ DELAY to mask this; the block does not enforce it.

## Test plan
- Exact match, N_CH=2, DELAY=0, TOL=0, WARMUP=4: identical ramps on A and B with en=1 → state goes 1 then 2 after 4 valid cycles; fail=0 and mismatch_cnt=0 after 100 cycles.
- Single-LSB error: B ch1 = A+1 at counted cycle 10, TOL=0 → mismatch=2'b10 one cycle later; fail=1; fail_ch=1; fail_a/fail_b hold those values; count=1; state=3. A later error on ch0 leaves the capture unchanged and makes count=2.
- Tolerance: TOL=2, diffs of +2, −2, then −3 → only −3 flags; no overflow with A=−2^24, B=2^24−1.
- Alignment: DELAY=3, B = A delayed by 3 cycles externally → no mismatch. With DELAY=2 → mismatch on every ramp step.
- Saturation and clear: CNT_W=4 with continuous mismatch → count sticks at 15. A clr pulse gives count=0, fail=0, state=0. With en still 1, WARM follows on the next edge.
- Async reset mid-FAIL: drop rst between clock edges → all outputs 0 immediately, without waiting for a clock edge.
